// File: rtl/buzzer_seq.sv
// Melody sequencer: plays up to 8 table entries (half-period + duration) into a
// square-wave tone generator, with a silent gap after each note and optional looping.
module buzzer_seq #(
  parameter int CLK_HZ  = 25000000,
  parameter int TICK_HZ = 1000,
  parameter int GAP_MS  = 20,
  parameter int PW      = 20,
  parameter int DW      = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [PW-1:0] wr_half_period,
  input  logic [DW-1:0] wr_dur,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [3:0]    len,
  output logic          busy,
  output logic          done,
  output logic [2:0]    note_idx,
  output logic          tone_en,
  output logic [PW-1:0] half_period
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  // +1 keeps the prescaler at least one bit wide even when TICK_DIV is 1
  localparam int PRE_W = $clog2(TICK_DIV + 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DW-1:0]    GAP_LAST = DW'((GAP_MS == 0) ? 0 : GAP_MS - 1);

  typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

  state_t          state, state_nx;
  logic [PRE_W-1:0] pre_cnt, pre_nx;
  logic [DW-1:0]   tick_cnt, tick_nx;
  logic [DW-1:0]   dur_lat, dur_nx;
  logic [3:0]      len_lat, len_nx;
  logic            busy_nx, done_nx, tone_en_nx;
  logic [2:0]      idx_nx;
  logic [PW-1:0]   hp_nx;

  logic [PW-1:0]   tab_hp  [8];
  logic [DW-1:0]   tab_dur [8];

  logic            tick_end, adv, ld;
  logic [2:0]      ld_idx;

  // Note table: cleared on reset, one write port; loads see the pre-write value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        tab_hp[i]  <= '0;
        tab_dur[i] <= '0;
      end
    end else if (wr_en) begin
      tab_hp[wr_addr]  <= wr_half_period;
      tab_dur[wr_addr] <= wr_dur;
    end
  end

  // State, counters and all outputs registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pre_cnt     <= '0;
      tick_cnt    <= '0;
      dur_lat     <= '0;
      len_lat     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      note_idx    <= '0;
      tone_en     <= 1'b0;
      half_period <= '0;
    end else begin
      state       <= state_nx;
      pre_cnt     <= pre_nx;
      tick_cnt    <= tick_nx;
      dur_lat     <= dur_nx;
      len_lat     <= len_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      note_idx    <= idx_nx;
      tone_en     <= tone_en_nx;
      half_period <= hp_nx;
    end
  end

  // Next-state / next-output logic; stop overrides everything at the end
  always_comb begin
    state_nx   = state;
    dur_nx     = dur_lat;
    len_nx     = len_lat;
    busy_nx    = busy;
    done_nx    = 1'b0;
    idx_nx     = note_idx;
    tone_en_nx = tone_en;
    hp_nx      = half_period;
    adv        = 1'b0;
    ld         = 1'b0;
    ld_idx     = '0;

    tick_end = (pre_cnt == PRE_LAST);
    pre_nx   = tick_end ? '0 : pre_cnt + 1'b1;
    tick_nx  = tick_end ? tick_cnt + 1'b1 : tick_cnt;

    case (state)
      IDLE: begin
        pre_nx  = '0;
        tick_nx = '0;
        if (start && (len != 4'd0)) begin
          len_nx = (len > 4'd8) ? 4'd8 : len;
          ld     = 1'b1;
        end
      end
      NOTE: begin
        if (tick_end && (tick_cnt == dur_lat - 1'b1)) begin
          if (GAP_MS != 0) begin
            state_nx   = GAP;
            tone_en_nx = 1'b0;
            pre_nx     = '0;
            tick_nx    = '0;
          end else begin
            adv = 1'b1;
          end
        end
      end
      GAP: begin
        if (tick_end && (tick_cnt == GAP_LAST)) adv = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    // Move to the next entry, wrap on loop, or finish naturally
    if (adv) begin
      if ({1'b0, note_idx} < (len_lat - 4'd1)) begin
        ld     = 1'b1;
        ld_idx = note_idx + 3'd1;
      end else if (loop) begin
        ld = 1'b1;
      end else begin
        state_nx   = IDLE;
        busy_nx    = 1'b0;
        tone_en_nx = 1'b0;
        idx_nx     = '0;
        done_nx    = 1'b1;
        pre_nx     = '0;
        tick_nx    = '0;
      end
    end

    // Enter NOTE: latch the entry so later table writes don't disturb this note
    if (ld) begin
      state_nx   = NOTE;
      busy_nx    = 1'b1;
      idx_nx     = ld_idx;
      hp_nx      = tab_hp[ld_idx];
      tone_en_nx = (tab_hp[ld_idx] != '0);
      dur_nx     = (tab_dur[ld_idx] == '0) ? DW'(1) : tab_dur[ld_idx];
      pre_nx     = '0;
      tick_nx    = '0;
    end

    if (stop) begin
      state_nx   = IDLE;
      busy_nx    = 1'b0;
      tone_en_nx = 1'b0;
      idx_nx     = '0;
      done_nx    = 1'b0;
      pre_nx     = '0;
      tick_nx    = '0;
    end
  end

endmodule

// File: tb/tb_buzzer_seq.sv
// Scoreboard bench for buzzer_seq: stimulus pushes expected output segments
// (output tuple + run length in cycles); a monitor collapses DUT outputs into
// runs and compares each finished run against the queue.
module tb_buzzer_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [19:0] wr_half_period;
  logic [11:0] wr_dur;
  logic        start, stop, loop;
  logic [3:0]  len;
  logic        busy, done, tone_en;
  logic [2:0]  note_idx;
  logic [19:0] half_period;

  buzzer_seq #(.CLK_HZ(1000), .TICK_HZ(100), .GAP_MS(2), .PW(20), .DW(12)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_half_period(wr_half_period), .wr_dur(wr_dur), .start(start), .stop(stop),
    .loop(loop), .len(len), .busy(busy), .done(done), .note_idx(note_idx),
    .tone_en(tone_en), .half_period(half_period)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] tup;  // {tone_en, half_period, note_idx, busy, done}
    int          len;  // 0 = any length
  } seg_t;

  seg_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic flush  = 1'b0;

  task automatic push(input logic te, input logic [19:0] hp, input logic [2:0] idx,
                      input logic b, input logic d, input int n);
    seg_t s;
    s.tup = {te, hp, idx, b, d};
    s.len = n;
    exp_q.push_back(s);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [19:0] hp, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_half_period = hp; wr_dur = d;
    tick(1);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Monitor: track runs of identical output tuples, check each run as it ends
  logic [25:0] run_tup;
  int          run_len  = 0;
  int          seg_no   = 0;
  logic        started  = 1'b0;
  logic        flushed  = 1'b0;

  task automatic check_run();
    seg_t s;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL seg%0d extra: got te=%0b hp=%0d idx=%0d busy=%0b done=%0b len=%0d, no segment expected",
               seg_no, run_tup[25], run_tup[24:5], run_tup[4:2], run_tup[1], run_tup[0], run_len);
    end else begin
      s = exp_q.pop_front();
      if (s.tup != run_tup || (s.len != 0 && s.len != run_len)) begin
        errors++;
        $display("FAIL seg%0d: got te=%0b hp=%0d idx=%0d busy=%0b done=%0b len=%0d, expected te=%0b hp=%0d idx=%0d busy=%0b done=%0b len=%0d",
                 seg_no, run_tup[25], run_tup[24:5], run_tup[4:2], run_tup[1], run_tup[0], run_len,
                 s.tup[25], s.tup[24:5], s.tup[4:2], s.tup[1], s.tup[0], s.len);
      end
    end
    seg_no++;
  endtask

  always @(negedge clk) begin
    logic [25:0] cur;
    cur = {tone_en, half_period, note_idx, busy, done};
    if (flush && !flushed) begin
      flushed = 1'b1;
      check_run();
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: got %0d segments unseen, expected 0", exp_q.size());
      end
    end else if (mon_en && !flushed) begin
      if (!started) begin
        started = 1'b1;
        run_tup = cur;
        run_len = 1;
      end else if (cur == run_tup) begin
        run_len++;
      end else begin
        check_run();
        run_tup = cur;
        run_len = 1;
      end
    end
  end

  initial begin
    rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_half_period = '0; wr_dur = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; len = 4'd0;
    #2 rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    push(0, 0, 0, 0, 0, 0);          // reset state
    mon_en = 1'b1;

    // Two-entry melody: tone, gap, rest (note+gap merge), done pulse
    wr(0, 5, 3); wr(1, 0, 1);
    len = 4'd2; loop = 1'b0;
    push(1, 5, 0, 1, 0, 30); push(0, 5, 0, 1, 0, 20); push(0, 0, 1, 1, 0, 30);
    push(0, 0, 0, 0, 1, 1);  push(0, 0, 0, 0, 0, 0);
    pulse_start(); tick(100);

    // Looping: second pass with no done in between, loop dropped mid second pass
    loop = 1'b1;
    push(1, 5, 0, 1, 0, 30); push(0, 5, 0, 1, 0, 20); push(0, 0, 1, 1, 0, 30);
    push(1, 5, 0, 1, 0, 30); push(0, 5, 0, 1, 0, 20); push(0, 0, 1, 1, 0, 30);
    push(0, 0, 0, 0, 1, 1);  push(0, 0, 0, 0, 0, 0);
    pulse_start(); tick(99); loop = 1'b0; tick(80);

    // Stop 7 cycles into e0: no done, half_period held
    push(1, 5, 0, 1, 0, 7); push(0, 5, 0, 0, 0, 0);
    pulse_start(); tick(6); stop = 1'b1; tick(1); stop = 1'b0; tick(10);

    // dur=0 plays as 1 tick; len=0 and start+stop produce no activity
    wr(0, 5, 0); len = 4'd1;
    push(1, 5, 0, 1, 0, 10); push(0, 5, 0, 1, 0, 20); push(0, 5, 0, 0, 1, 1);
    push(0, 5, 0, 0, 0, 0);
    pulse_start(); tick(40);
    len = 4'd0; pulse_start(); tick(5);
    len = 4'd1; start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0; tick(5);

    // Rewrite e0 during play: looped second pass picks up hp=9
    wr(0, 5, 3); len = 4'd1; loop = 1'b1;
    push(1, 5, 0, 1, 0, 30); push(0, 5, 0, 1, 0, 20); push(1, 9, 0, 1, 0, 30);
    push(0, 9, 0, 1, 0, 20); push(0, 9, 0, 0, 1, 1);  push(0, 9, 0, 0, 0, 0);
    pulse_start(); tick(4); wr(0, 9, 3); tick(55); loop = 1'b0; tick(60);

    // Reset 5 cycles into the e0 gap, then replay: cleared table gives a 1-tick rest
    len = 4'd2;
    push(1, 9, 0, 1, 0, 30); push(0, 9, 0, 1, 0, 5); push(0, 0, 0, 0, 0, 0);
    pulse_start(); tick(35);
    rst_n = 1'b0; tick(3); rst_n = 1'b1;
    len = 4'd1;
    push(0, 0, 0, 1, 0, 30); push(0, 0, 0, 0, 1, 1); push(0, 0, 0, 0, 0, 0);
    pulse_start(); tick(40);

    flush = 1'b1;
    tick(3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
